// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit limits and prescaler width helper
package stopwatch_pkg;
  typedef enum logic [2:0] {IDLE, RUN, STOP, LAP_RUN, LAP_STOP} state_t;
  localparam int DECI_MAX = 9;
  localparam int SEC0_MAX = 9;
  localparam int SEC1_MAX = 5;
  localparam int MIN_MAX = 9;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one wrapping counter digit with cascade carry and saturation hold
module bcd_digit #(
  parameter int W = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         sclr,
  input  logic         en,
  input  logic         hold,
  output logic [W-1:0] q,
  output logic         carry
);
  assign carry = en & (q == W'(MAX));
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) q <= '0;
    else if (sclr) q <= '0;
    else if (en && !hold) q <= carry ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: prescaled BCD stopwatch with run/stop, lap freeze, clear and overflow policy
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int MIN_DIGITS = 1,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [3:0]              deci,
  output logic [3:0]              sec0,
  output logic [2:0]              sec1,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic                    running,
  output logic                    lap_held,
  output logic                    ovf
);
  localparam int PW = clog2(CLK_DIV);
  localparam int MW = 4 * MIN_DIGITS;
  state_t state, nxt;
  logic [PW-1:0] presc;
  logic [3:0] deci_q, sec0_q, deci_l, sec0_l;
  logic [2:0] sec1_q, sec1_l;
  logic [MW-1:0] min_q, min_l;
  logic [MIN_DIGITS:0] men;
  logic tick, c_deci, c_sec0, hold, ovf_evt, ss, lp;
  assign tick = running & (presc == PW'(CLK_DIV - 1));
  assign ovf_evt = men[MIN_DIGITS];
  assign hold = (SATURATE != 0) && ovf_evt;
  assign ss = start_stop & ~clear;
  assign lp = lap & ~clear & ~start_stop;
  bcd_digit #(.W(4), .MAX(DECI_MAX)) u_deci (
    .clk(clk), .clr_n(clr_n), .sclr(clear), .en(tick), .hold(hold), .q(deci_q), .carry(c_deci)
  );
  bcd_digit #(.W(4), .MAX(SEC0_MAX)) u_sec0 (
    .clk(clk), .clr_n(clr_n), .sclr(clear), .en(c_deci), .hold(hold), .q(sec0_q), .carry(c_sec0)
  );
  bcd_digit #(.W(3), .MAX(SEC1_MAX)) u_sec1 (
    .clk(clk), .clr_n(clr_n), .sclr(clear), .en(c_sec0), .hold(hold), .q(sec1_q), .carry(men[0])
  );
  for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
    bcd_digit #(.W(4), .MAX(MIN_MAX)) u_min (
      .clk(clk), .clr_n(clr_n), .sclr(clear), .en(men[i]), .hold(hold),
      .q(min_q[4*i +: 4]), .carry(men[i+1])
    );
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = ss ? RUN : IDLE;
      RUN:      nxt = ss ? STOP : lp ? LAP_RUN : RUN;
      STOP:     nxt = ss ? RUN : STOP;
      LAP_RUN:  nxt = ss ? LAP_STOP : lp ? RUN : LAP_RUN;
      LAP_STOP: nxt = ss ? LAP_RUN : lp ? STOP : LAP_STOP;
      default:  nxt = IDLE;
    endcase
    // saturation stops time but preserves the freeze state
    if (hold) nxt = (nxt == RUN) ? STOP : (nxt == LAP_RUN) ? LAP_STOP : nxt;
    if (clear) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      running <= 1'b0;
      lap_held <= 1'b0;
      ovf <= 1'b0;
      presc <= '0;
      deci_l <= '0;
      sec0_l <= '0;
      sec1_l <= '0;
      min_l <= '0;
    end else begin
      state <= nxt;
      running <= (nxt == RUN) || (nxt == LAP_RUN);
      lap_held <= (nxt == LAP_RUN) || (nxt == LAP_STOP);
      ovf <= ~clear & (ovf | ovf_evt);
      presc <= (clear || tick) ? '0 : running ? presc + 1'b1 : presc;
      if (clear) begin
        deci_l <= '0;
        sec0_l <= '0;
        sec1_l <= '0;
        min_l <= '0;
      end else if (lp && state == RUN) begin
        deci_l <= deci_q;
        sec0_l <= sec0_q;
        sec1_l <= sec1_q;
        min_l <= min_q;
      end
    end
  assign deci = lap_held ? deci_l : deci_q;
  assign sec0 = lap_held ? sec0_l : sec0_q;
  assign sec1 = lap_held ? sec1_l : sec1_q;
  assign min = lap_held ? min_l : min_q;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Fully synchronous, parametrised stopwatch. It replaces the ripple-clocked digit chain with one clock plus cascaded enables, and adds a clock prescaler, start/stop, lap-freeze display, synchronous clear, configurable minute digits and an overflow policy. It sits between the debounced/synchronised front-panel strobes and the 7-segment display driver, and outputs BCD digits.

Parameters:
CLK_DIV, 10, clk cycles per 0.1 s tick (≥2)
MIN_DIGITS, 1, number of BCD minute digits (1..3)
SATURATE, 1, 1 = hold at max and stop on overflow; 0 = wrap to all-zero and keep running

Ports:
clk  in  1  system clock, all logic rising-edge
clr_n  in  1  asynchronous active-low reset
start_stop  in  1  single-cycle strobe: toggle run/stop
lap  in  1  single-cycle strobe: toggle display freeze
clear  in  1  single-cycle strobe: synchronous return to zero/idle
deci  out  4  tenths digit, BCD 0..9
sec0  out  4  seconds units, BCD 0..9
sec1  out  3  seconds tens, 0..5
min  out  4*MIN_DIGITS  minutes, BCD, least significant digit in [3:0]
running  out  1  1 while time is advancing
lap_held  out  1  1 while the display is frozen
ovf  out  1  sticky overflow flag

Behaviour:
- clr_n low (async): all counters, prescaler, lap registers, state and ovf are 0. State is IDLE and all outputs are 0.
- Prescaler: counts 0..CLK_DIV-1 only while running. tick = running & (presc==CLK_DIV-1). On a tick the prescaler returns to 0. On stop it keeps its value, so no fraction of a tick is lost.
- Digit chain: deci increments on tick.
  - Each digit wraps to 0 at its max: deci 9, sec0 9, sec1 5, each minute digit 9.
  - The next digit is enabled on (own enable & own value==max).
  - All digits update on the same edge. The count is visible one cycle after the tick cycle.
- States: IDLE, RUN, STOP, LAP_RUN, LAP_STOP.
  - IDLE: start_stop → RUN.
  - RUN: start_stop → STOP; lap → LAP_RUN.
  - STOP: start_stop → RUN; lap is ignored.
  - LAP_RUN: lap → RUN; start_stop → LAP_STOP.
  - LAP_STOP: lap → STOP; start_stop → LAP_RUN.
- running = 1 in RUN and LAP_RUN. lap_held = 1 in LAP_RUN and LAP_STOP.
- Display mux:
  - lap_held=0: outputs show the live counters.
  - lap_held=1: outputs show the lap registers.
  - Lap registers capture the live counters on the edge where lap moves the FSM into a LAP_* state. The captured value is the pre-increment value if a tick occurs on that same edge.
  - The live count keeps advancing while frozen in LAP_RUN.
- Priority in one cycle: clear > start_stop > lap. lap is ignored in any cycle where start_stop or clear is active.
- clear: the next state is IDLE. Counters, prescaler, lap registers and ovf go to 0. This holds from any state, including mid-tick and while frozen.
- Overflow: a tick while every digit is at max (min all 9s, sec1 5, sec0 9, deci 9).
  - SATURATE=1: counters hold max, ovf is set, and the FSM goes to STOP (or LAP_STOP if frozen).
  - SATURATE=0: counters wrap to 0, ovf is set, and the FSM stays in its state.
  - ovf clears only on clear or reset.
- start_stop while ovf=1 and SATURATE=1: the FSM enters RUN, but the count does not advance. Each tick re-asserts the saturation and the FSM returns to STOP.
- Input strobes held high for several cycles act once per cycle. Callers must supply single-cycle pulses.

Decomposition:
- stopwatch_pkg holds:
  - the state enum (IDLE, RUN, STOP, LAP_RUN, LAP_STOP);
  - digit max constants (DECI_MAX=9, SEC0_MAX=9, SEC1_MAX=5, MIN_MAX=9);
  - the prescaler width function clog2(CLK_DIV).
- One sub-module, bcd_digit:
  - parameters W and MAX;
  - ports clk, clr_n, sclr, en, hold, q, carry;
  - carry = en & (q==MAX).
- bcd_digit is instantiated 3+MIN_DIGITS times with a generate loop for the minutes.

Test Plan:
- Reset: clr_n=0 mid-count, then release → all outputs 0, running=0, lap_held=0, ovf=0, and no tick until start_stop.
- Timing (CLK_DIV=4): start_stop, then 40 clk → deci goes 1,2,..9,0 and sec0=1. Stop after 6 clk, restart → the next tick arrives 2 clk after restart (fraction retained).
- Lap (CLK_DIV=4, run to 0:12.3): lap → display frozen at min=0 sec1=1 sec0=2 deci=3 while running=1. Second lap 20 clk later → display shows live 0:12.8.
- Minute rollover (MIN_DIGITS=2): run to 00:59.9, then one tick → min=0x01, sec1=0, sec0=0, deci=0.
- Overflow (MIN_DIGITS=1): from 9:59.9, one tick → SATURATE=1 gives 9:59.9 held, ovf=1, running=0. SATURATE=0 gives 0:00.0, ovf=1, running=1.
- Simultaneous events: clear+start_stop+lap in the same cycle → IDLE with all zeros. start_stop+lap in RUN → STOP with lap_held=0.
